// File: rtl/alu_rs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_rs_pkg
// Description : Shared constants for the ALU reservation station: opcode
//               encodings (including the null opcode), ROB-id width, the
//               32-bit null value and the default station depth.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int ROB_W_DEF   = 4;
    localparam int OP_W_DEF    = 6;

    localparam logic [31:0] NULL32 = 32'h0000_0000;

    // Internal ALU / branch / JALR opcodes
    localparam logic [OP_W_DEF-1:0] OP_NULL = 6'd0;
    localparam logic [OP_W_DEF-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 6'd3;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 6'd4;
    localparam logic [OP_W_DEF-1:0] OP_XOR  = 6'd5;
    localparam logic [OP_W_DEF-1:0] OP_SLL  = 6'd6;
    localparam logic [OP_W_DEF-1:0] OP_SRL  = 6'd7;
    localparam logic [OP_W_DEF-1:0] OP_SRA  = 6'd8;
    localparam logic [OP_W_DEF-1:0] OP_SLT  = 6'd9;
    localparam logic [OP_W_DEF-1:0] OP_SLTU = 6'd10;
    localparam logic [OP_W_DEF-1:0] OP_BEQ  = 6'd11;
    localparam logic [OP_W_DEF-1:0] OP_BNE  = 6'd12;
    localparam logic [OP_W_DEF-1:0] OP_BLT  = 6'd13;
    localparam logic [OP_W_DEF-1:0] OP_BGE  = 6'd14;
    localparam logic [OP_W_DEF-1:0] OP_BLTU = 6'd15;
    localparam logic [OP_W_DEF-1:0] OP_BGEU = 6'd16;
    localparam logic [OP_W_DEF-1:0] OP_JALR = 6'd17;

endpackage : alu_rs_pkg
`default_nettype wire

// File: rtl/alu_rs_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_rs_if
// Description : Issue, CDB snoop and ALU dispatch signals of the ALU
//               reservation station. The slave modport is the station; the
//               master modport is the surrounding core (issue stage, CDB
//               arbiter and ALU).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rs_if
    import alu_rs_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF,
    parameter int OP_W  = OP_W_DEF
);
    // Issue side
    logic             issue_valid;
    logic [OP_W-1:0]  issue_op;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;
    logic             issue_qj_busy;
    logic             issue_qk_busy;
    logic [ROB_W-1:0] issue_qj;
    logic [ROB_W-1:0] issue_qk;
    logic [ROB_W-1:0] issue_dest;
    logic             rs_full;

    // Common data bus snoop
    logic             cdb_alu_valid;
    logic [ROB_W-1:0] cdb_alu_rob;
    logic [31:0]      cdb_alu_val;
    logic             cdb_lsb_valid;
    logic [ROB_W-1:0] cdb_lsb_rob;
    logic [31:0]      cdb_lsb_val;

    // Dispatch to the ALU
    logic             alu_flag;
    logic [31:0]      alu_val1;
    logic [31:0]      alu_val2;
    logic [OP_W-1:0]  alu_opcode;
    logic [ROB_W-1:0] alu_rob;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_dest,
               cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
               cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val,
        input  rs_full, alu_flag, alu_val1, alu_val2, alu_opcode, alu_rob
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_dest,
               cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
               cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val,
        output rs_full, alu_flag, alu_val1, alu_val2, alu_opcode, alu_rob
    );

endinterface : alu_rs_if
`default_nettype wire

// File: rtl/alu_rs_find_first.sv
`default_nettype none
// ============================================================================
// Module      : rs_find_first
// Description : Find-first-set over an RS_SIZE-bit vector. Returns whether
//               any bit is set and the index of the lowest set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_find_first #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1
) (
    input  wire logic [RS_SIZE-1:0] vec_i,
    output logic                    found_o,
    output logic [IDX_W-1:0]        idx_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule : rs_find_first
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs
// Description : Reservation station for the integer ALU. Holds issued ops
//               until both operands are known, snoops the ALU and LSB CDB
//               ports for wakeup (with same-cycle bypass at issue), and
//               dispatches one ready op per cycle to the combinational ALU.
// Optional    : ALU_RS_AGE_ORDER_EN - per-entry age counters; select picks
//               the oldest ready entry instead of the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic flush_in,
    alu_rs_if.slave   bus
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Per-entry state
    logic [RS_SIZE-1:0] busy_q;
    logic [RS_SIZE-1:0] qj_busy_q;
    logic [RS_SIZE-1:0] qk_busy_q;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [31:0]        vk_q   [RS_SIZE];
    logic [ROB_W-1:0]   qj_q   [RS_SIZE];
    logic [ROB_W-1:0]   qk_q   [RS_SIZE];
    logic [ROB_W-1:0]   dest_q [RS_SIZE];

    // Dispatch output registers
    logic               alu_flag_q;
    logic [31:0]        alu_val1_q;
    logic [31:0]        alu_val2_q;
    logic [OP_W-1:0]    alu_opcode_q;
    logic [ROB_W-1:0]   alu_rob_q;

    // Allocation / select
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [RS_SIZE-1:0] ready_vec;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue_ok;

    // Issue operands after CDB bypass
    logic               iss_qj_busy;
    logic               iss_qk_busy;
    logic [31:0]        iss_vj;
    logic [31:0]        iss_vk;

    assign issue_ok  = bus.issue_valid && free_found;
    assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;

    rs_find_first #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_free_ff (
        .vec_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

`ifdef ALU_RS_AGE_ORDER_EN
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_SIZE - 1);

    logic [IDX_W-1:0] age_q [RS_SIZE];
    logic [IDX_W-1:0] best_age;

    // Oldest ready entry; strict compare keeps the lower index on ties
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_vec[i] && (!sel_found || (age_q[i] > best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age_q[i];
            end
        end
    end

    // Age counters: new entry starts at zero, every other busy entry ages
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                age_q[i] <= '0;
            end
        end else if (!flush_in && issue_ok) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_q[i] <= age_q[i] + IDX_W'(1);
                end
            end
            age_q[free_idx] <= '0;
        end
    end
`else
    rs_find_first #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_ready_ff (
        .vec_i   (ready_vec),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );
`endif

    // Same-cycle bypass of CDB results into the issuing op; ALU port wins
    always_comb begin
        iss_qj_busy = bus.issue_qj_busy;
        iss_vj      = bus.issue_vj;
        iss_qk_busy = bus.issue_qk_busy;
        iss_vk      = bus.issue_vk;
        if (bus.issue_qj_busy) begin
            if (bus.cdb_alu_valid && (bus.cdb_alu_rob == bus.issue_qj)) begin
                iss_qj_busy = 1'b0;
                iss_vj      = bus.cdb_alu_val;
            end else if (bus.cdb_lsb_valid && (bus.cdb_lsb_rob == bus.issue_qj)) begin
                iss_qj_busy = 1'b0;
                iss_vj      = bus.cdb_lsb_val;
            end
        end
        if (bus.issue_qk_busy) begin
            if (bus.cdb_alu_valid && (bus.cdb_alu_rob == bus.issue_qk)) begin
                iss_qk_busy = 1'b0;
                iss_vk      = bus.cdb_alu_val;
            end else if (bus.cdb_lsb_valid && (bus.cdb_lsb_rob == bus.issue_qk)) begin
                iss_qk_busy = 1'b0;
                iss_vk      = bus.cdb_lsb_val;
            end
        end
    end

    // Entry bookkeeping: wakeup, dispatch and issue, with reset then flush priority
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q       <= '0;
            qj_busy_q    <= '0;
            qk_busy_q    <= '0;
            alu_flag_q   <= 1'b0;
            alu_val1_q   <= NULL32;
            alu_val2_q   <= NULL32;
            alu_opcode_q <= OP_W'(OP_NULL);
            alu_rob_q    <= '0;
        end else if (flush_in) begin
            busy_q     <= '0;
            qj_busy_q  <= '0;
            qk_busy_q  <= '0;
            alu_flag_q <= 1'b0;
        end else begin
            // Wakeup from either CDB port; ALU port wins on a shared tag
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (bus.cdb_alu_valid && (bus.cdb_alu_rob == qj_q[i])) begin
                        qj_busy_q[i] <= 1'b0;
                        vj_q[i]      <= bus.cdb_alu_val;
                    end else if (bus.cdb_lsb_valid && (bus.cdb_lsb_rob == qj_q[i])) begin
                        qj_busy_q[i] <= 1'b0;
                        vj_q[i]      <= bus.cdb_lsb_val;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (bus.cdb_alu_valid && (bus.cdb_alu_rob == qk_q[i])) begin
                        qk_busy_q[i] <= 1'b0;
                        vk_q[i]      <= bus.cdb_alu_val;
                    end else if (bus.cdb_lsb_valid && (bus.cdb_lsb_rob == qk_q[i])) begin
                        qk_busy_q[i] <= 1'b0;
                        vk_q[i]      <= bus.cdb_lsb_val;
                    end
                end
            end

            // Dispatch: outputs hold when nothing is ready
            alu_flag_q <= sel_found;
            if (sel_found) begin
                alu_val1_q       <= vj_q[sel_idx];
                alu_val2_q       <= vk_q[sel_idx];
                alu_opcode_q     <= op_q[sel_idx];
                alu_rob_q        <= dest_q[sel_idx];
                busy_q[sel_idx]  <= 1'b0;
            end

            // Issue into a slot that was free before this edge
            if (issue_ok) begin
                busy_q[free_idx]    <= 1'b1;
                op_q[free_idx]      <= bus.issue_op;
                vj_q[free_idx]      <= iss_vj;
                vk_q[free_idx]      <= iss_vk;
                qj_busy_q[free_idx] <= iss_qj_busy;
                qk_busy_q[free_idx] <= iss_qk_busy;
                qj_q[free_idx]      <= bus.issue_qj;
                qk_q[free_idx]      <= bus.issue_qk;
                dest_q[free_idx]    <= bus.issue_dest;
            end
        end
    end

    assign bus.rs_full    = &busy_q;
    assign bus.alu_flag   = alu_flag_q;
    assign bus.alu_val1   = alu_val1_q;
    assign bus.alu_val2   = alu_val2_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_rob    = alu_rob_q;

endmodule : alu_rs
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rs
// Description : Self-checking bench for alu_rs. Directed issue/CDB vectors
//               push expected dispatches into a scoreboard queue; a monitor
//               pops and compares on every alu_flag pulse.
// Optional    : ALU_RS_AGE_ORDER_EN changes the expected order in the
//               age-ordering scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs;
    import alu_rs_pkg::*;

    typedef struct packed {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [5:0]  op;
        logic [3:0]  rob;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    int checks = 0;
    int errors = 0;
    exp_t sb [$];
    exp_t mon_e;
    exp_t mon_a;

    alu_rs_if #(.ROB_W(4), .OP_W(6)) bus ();

    alu_rs #(.RS_SIZE(16), .ROB_W(4), .OP_W(6)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .flush_in (flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every dispatch pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.alu_flag) begin
            checks++;
            mon_a = '{v1: bus.alu_val1, v2: bus.alu_val2, op: bus.alu_opcode, rob: bus.alu_rob};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dispatch_unexpected: actual rob=%0d v1=%h v2=%h op=%0d, required no dispatch",
                         mon_a.rob, mon_a.v1, mon_a.v2, mon_a.op);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL dispatch: actual rob=%0d v1=%h v2=%h op=%0d, required rob=%0d v1=%h v2=%h op=%0d",
                             mon_a.rob, mon_a.v1, mon_a.v2, mon_a.op,
                             mon_e.rob, mon_e.v1, mon_e.v2, mon_e.op);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] v1, input logic [31:0] v2,
                            input logic [5:0] op, input logic [3:0] rob);
        sb.push_back('{v1: v1, v2: v2, op: op, rob: rob});
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjb, input logic [3:0] qj,
                             input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_vj      = vj;
        bus.issue_vk      = vk;
        bus.issue_qj_busy = qjb;
        bus.issue_qj      = qj;
        bus.issue_qk_busy = qkb;
        bus.issue_qk      = qk;
        bus.issue_dest    = dest;
    endtask

    task automatic clr();
        bus.issue_valid   = 1'b0;
        bus.cdb_alu_valid = 1'b0;
        bus.cdb_lsb_valid = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic issue_tick(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic qjb, input logic [3:0] qj,
                              input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
        set_issue(op, vj, vk, qjb, qj, qkb, qk, dest);
        tick();
        clr();
    endtask

    task automatic cdb_alu(input logic [3:0] rob, input logic [31:0] val);
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_rob   = rob;
        bus.cdb_alu_val   = val;
    endtask

    task automatic cdb_lsb(input logic [3:0] rob, input logic [31:0] val);
        bus.cdb_lsb_valid = 1'b1;
        bus.cdb_lsb_rob   = rob;
        bus.cdb_lsb_val   = val;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        set_issue(6'd0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        bus.issue_valid = 1'b0;
        cdb_alu(4'd0, 32'h0);
        cdb_lsb(4'd0, 32'h0);
        clr();

        // Reset state
        tick();
        tick();
        chk("rst_flag",    {31'd0, bus.alu_flag}, 32'd0);
        chk("rst_val1",    bus.alu_val1, 32'd0);
        chk("rst_val2",    bus.alu_val2, 32'd0);
        chk("rst_rob",     {28'd0, bus.alu_rob}, 32'd0);
        chk("rst_opcode",  {26'd0, bus.alu_opcode}, 32'd0);
        chk("rst_full",    {31'd0, bus.rs_full}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: ready ADD dispatches one edge after issue, single-cycle pulse
        push_exp(32'd5, 32'd7, OP_ADD, 4'd3);
        issue_tick(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        chk("t1_no_dispatch_at_issue", {31'd0, bus.alu_flag}, 32'd0);
        tick();
        chk("t1_flag", {31'd0, bus.alu_flag}, 32'd1);
        tick();
        chk("t1_flag_pulse", {31'd0, bus.alu_flag}, 32'd0);

        // 2: SUB waits on qj=2, woken by the LSB port
        issue_tick(OP_SUB, 32'hDEAD_BEEF, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
        tick();
        chk("t2_blocked", {31'd0, bus.alu_flag}, 32'd0);
        cdb_lsb(4'd2, 32'd10);
        push_exp(32'd10, 32'd1, OP_SUB, 4'd5);
        tick();
        clr();
        chk("t2_wake_edge", {31'd0, bus.alu_flag}, 32'd0);
        tick();
        chk("t2_flag", {31'd0, bus.alu_flag}, 32'd1);

        // 3: same-cycle bypass on qk from the ALU port
        set_issue(OP_AND, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
        cdb_alu(4'd4, 32'hFFFF_FFFF);
        push_exp(32'd3, 32'hFFFF_FFFF, OP_AND, 4'd6);
        tick();
        clr();
        tick();

        // 3b: both ports carry the same tag at issue; ALU port value wins
        set_issue(OP_OR, 32'd0, 32'd9, 1'b1, 4'd7, 1'b0, 4'd0, 4'd7);
        cdb_alu(4'd7, 32'h111);
        cdb_lsb(4'd7, 32'h222);
        push_exp(32'h111, 32'd9, OP_OR, 4'd7);
        tick();
        clr();
        tick();

        // Back-to-back issue with dispatch on the same edge
        push_exp(32'd20, 32'd21, OP_XOR, 4'd8);
        push_exp(32'd30, 32'd31, OP_JALR, 4'd9);
        issue_tick(OP_XOR, 32'd20, 32'd21, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        issue_tick(OP_JALR, 32'd30, 32'd31, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        tick();

        // 4: fill all 16 entries, drop the 17th, wake entry 0
        issue_tick(OP_ADD, 32'd0, 32'h40, 1'b1, 4'd8, 1'b0, 4'd0, 4'd0);
        for (int i = 1; i < 16; i++) begin
            issue_tick(OP_SLT, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
            if (i == 14) chk("t4_not_full_at_15", {31'd0, bus.rs_full}, 32'd0);
        end
        chk("t4_full", {31'd0, bus.rs_full}, 32'd1);
        issue_tick(OP_ADD, 32'hBAD, 32'hBAD, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        chk("t4_full_after_drop", {31'd0, bus.rs_full}, 32'd1);
        cdb_alu(4'd8, 32'd100);
        push_exp(32'd100, 32'h40, OP_ADD, 4'd0);
        tick();
        clr();
        chk("t4_full_at_wake", {31'd0, bus.rs_full}, 32'd1);
        tick();
        chk("t4_dispatch_flag", {31'd0, bus.alu_flag}, 32'd1);
        chk("t4_not_full_after_dispatch", {31'd0, bus.rs_full}, 32'd0);

        // 5: flush with a pending ready op and a simultaneous issue
        flush = 1'b1;
        tick();
        clr();
        chk("t5_empty_after_flush", {31'd0, bus.rs_full}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            issue_tick(OP_SRL, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
        end
        issue_tick(OP_SRA, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
        set_issue(OP_ADD, 32'd4, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        flush = 1'b1;
        tick();
        clr();
        chk("t5_flag_on_flush", {31'd0, bus.alu_flag}, 32'd0);
        chk("t5_not_full", {31'd0, bus.rs_full}, 32'd0);
        cdb_alu(4'd9, 32'd55);
        tick();
        clr();
        tick();
        tick();
        chk("t5_nothing_left", {31'd0, bus.alu_flag}, 32'd0);

        // 6: older entry 5 and newer entry 1 become ready together
        issue_tick(OP_BEQ, 32'd0, 32'hA0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0);
        issue_tick(OP_BNE, 32'd0, 32'hA1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd1);
        issue_tick(OP_BLT, 32'd0, 32'hA2, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
        issue_tick(OP_BLT, 32'd0, 32'hA3, 1'b1, 4'd3, 1'b0, 4'd0, 4'd3);
        issue_tick(OP_BLT, 32'd0, 32'hA4, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4);
        issue_tick(OP_BGE, 32'd0, 32'hA5, 1'b1, 4'd5, 1'b0, 4'd0, 4'd5);
        cdb_lsb(4'd2, 32'h20);
        push_exp(32'h20, 32'hA1, OP_BNE, 4'd1);
        tick();
        clr();
        tick();
        issue_tick(OP_BGEU, 32'd0, 32'h61, 1'b1, 4'd5, 1'b0, 4'd0, 4'd11);
        cdb_alu(4'd5, 32'h55);
`ifdef ALU_RS_AGE_ORDER_EN
        push_exp(32'h55, 32'hA5, OP_BGE, 4'd5);
        push_exp(32'h55, 32'h61, OP_BGEU, 4'd11);
`else
        push_exp(32'h55, 32'h61, OP_BGEU, 4'd11);
        push_exp(32'h55, 32'hA5, OP_BGE, 4'd5);
`endif
        tick();
        clr();
        tick();
        tick();
        flush = 1'b1;
        tick();
        clr();

        // Every expected dispatch must have been observed
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_rs
`default_nettype wire
